// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU-control decoder: maps ALUOP plus a one-hot R-type func to a 3-bit
// ALU select, stretches selected func ops over several cycles, and counts illegal encodings.
module alu_ctrl_seq #(
   parameter int                FUNC_W    = 8,
   parameter logic [FUNC_W-1:0] MC_MASK   = '0,
   parameter int                MC_CYCLES = 4,
   parameter int                ERR_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        alu_op,
   input  logic [FUNC_W-1:0] func,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        alu_sel,
   output logic              illegal,
   output logic              mc_busy,
   output logic [ERR_W-1:0]  err_count
);

   localparam int CNT_W = $clog2(MC_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       dec_sel;
   logic             dec_illegal;
   logic             dec_mc;
   logic             accept;

   // Anything outside the seven legal one-hot funcs (zero, multi-hot, high bits) falls to default.
   always_comb begin
      dec_sel     = 3'b000;
      dec_illegal = 1'b0;
      case (alu_op)
         3'b000: dec_sel = 3'b000;
         3'b001: dec_sel = 3'b001;
         3'b010: dec_sel = 3'b011;
         3'b011: dec_sel = 3'b100;
         3'b111: begin
            case (func)
               FUNC_W'(7'h01): dec_sel = 3'b101;
               FUNC_W'(7'h02): dec_sel = 3'b000;
               FUNC_W'(7'h04): dec_sel = 3'b010;
               FUNC_W'(7'h08): dec_sel = 3'b011;
               FUNC_W'(7'h10): dec_sel = 3'b100;
               FUNC_W'(7'h20): dec_sel = 3'b110;
               FUNC_W'(7'h40): dec_sel = 3'b111;
               default: begin
                  dec_sel     = 3'b111;
                  dec_illegal = 1'b1;
               end
            endcase
         end
         default: begin
            dec_sel     = 3'b000;
            dec_illegal = 1'b1;
         end
      endcase
   end

   assign dec_mc = (alu_op == 3'b111) && !dec_illegal && (|(func & MC_MASK));
   assign accept = in_valid && in_ready;

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      mc_busy   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nx = dec_mc ? EXEC : DONE;
            end
         end
         EXEC: begin
            mc_busy = 1'b1;
            if (cnt == CNT_W'(1)) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  state_nx = dec_mc ? EXEC : DONE;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (accept && dec_mc) begin
            cnt <= CNT_W'(MC_CYCLES - 1);
         end else if (state == EXEC) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   // Result fields only move on accept so they stay stable while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_sel   <= 3'b000;
         illegal   <= 1'b0;
         err_count <= '0;
      end else if (accept) begin
         alu_sel <= dec_sel;
         illegal <= dec_illegal;
         if (dec_illegal && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
         end
      end
   end

endmodule
